keep_press_multi: RTL and testbench



---
 rtl/keep_press_pkg.sv | 15 +
 rtl/btn_channel.sv | 137 +++++++++++++
 rtl/keep_press_multi.sv | 39 +++
 tb/tb_keep_press_multi.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keep_press_pkg.sv
// rtl/keep_press_pkg.sv - shared state encoding and 10 Hz timing defaults for keep_press_multi
package keep_press_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HELD  = 2'd2
    } kp_state_t;

    // Tick counts at the 10 Hz system tick
    localparam int DEF_DEB_CYC  = 2;
    localparam int DEF_LONG_CYC = 10;
    localparam int DEF_REP_CYC  = 3;

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one pushbutton: sync, debounce, short/long classification, auto-repeat
module btn_channel
    import keep_press_pkg::*;
#(
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int LONG_CYC = DEF_LONG_CYC,
    parameter int REP_CYC  = DEF_REP_CYC,
    parameter int CNT_W    = 8
) (
    input  logic clk10hz,
    input  logic rst_n,
    input  logic pb,
    input  logic repEn,
    output logic pressed,
    output logic shortPulse,
    output logic isKP,
    output logic repPulse
);

    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    logic [1:0]       sync_q;
    logic             raw;
    logic             deb_q, deb_n;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_n;
    logic             rise, fall;
    kp_state_t        state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             short_q, short_n;
    logic             kp_q, kp_n;
    logic             rep_q, rep_n;

    // Synchroniser idles at 1 so a reset never looks like a press
    always_ff @(posedge clk10hz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pb};
        end
    end

    assign raw = ~sync_q[1];

    always_comb begin
        deb_n     = deb_q;
        deb_cnt_n = '0;
        if (raw != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_n = ~deb_q;
            end else begin
                deb_cnt_n = deb_cnt_q + 1'b1;
            end
        end
    end

    // The FSM follows the next debounced level so its outputs move on the same edge as pressed
    assign rise = deb_n & ~deb_q;
    assign fall = ~deb_n & deb_q;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        short_n = 1'b0;
        kp_n    = 1'b0;
        rep_n   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_n = ST_PRESS;
                    cnt_n   = '0;
                end
            end
            ST_PRESS: begin
                if (fall) begin
                    state_n = ST_IDLE;
                    short_n = 1'b1;
                    cnt_n   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_n = ST_HELD;
                    kp_n    = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    kp_n = 1'b1;
                    if (!repEn) begin
                        cnt_n = '0;
                    end else if (cnt_q == REP_LAST) begin
                        rep_n = 1'b1;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk10hz or negedge rst_n) begin
        if (!rst_n) begin
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            short_q   <= 1'b0;
            kp_q      <= 1'b0;
            rep_q     <= 1'b0;
        end else begin
            deb_q     <= deb_n;
            deb_cnt_q <= deb_cnt_n;
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            short_q   <= short_n;
            kp_q      <= kp_n;
            rep_q     <= rep_n;
        end
    end

    assign pressed    = deb_q;
    assign shortPulse = short_q;
    assign isKP       = kp_q;
    assign repPulse   = rep_q;

endmodule

// File: rtl/keep_press_multi.sv
// rtl/keep_press_multi.sv - N independent long-press detectors with auto-repeat
module keep_press_multi
    import keep_press_pkg::*;
#(
    parameter int N_BTN    = 4,
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int LONG_CYC = DEF_LONG_CYC,
    parameter int REP_CYC  = DEF_REP_CYC,
    parameter int CNT_W    = 8
) (
    input  logic             clk10hz,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] pb,
    input  logic [N_BTN-1:0] repEn,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] shortPulse,
    output logic [N_BTN-1:0] isKP,
    output logic [N_BTN-1:0] repPulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEB_CYC (DEB_CYC),
            .LONG_CYC(LONG_CYC),
            .REP_CYC (REP_CYC),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk10hz   (clk10hz),
            .rst_n     (rst_n),
            .pb        (pb[i]),
            .repEn     (repEn[i]),
            .pressed   (pressed[i]),
            .shortPulse(shortPulse[i]),
            .isKP      (isKP[i]),
            .repPulse  (repPulse[i])
        );
    end

endmodule

// File: tb/tb_keep_press_multi.sv
// tb/tb_keep_press_multi.sv - self-checking bench for keep_press_multi
module tb_keep_press_multi;

    localparam int N_BTN    = 4;
    localparam int DEB_CYC  = 2;
    localparam int LONG_CYC = 10;
    localparam int REP_CYC  = 3;

    logic             clk10hz = 1'b0;
    logic             rst_n;
    logic [N_BTN-1:0] pb;
    logic [N_BTN-1:0] repEn;
    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] shortPulse;
    logic [N_BTN-1:0] isKP;
    logic [N_BTN-1:0] repPulse;

    always #5 clk10hz = ~clk10hz;

    keep_press_multi #(
        .N_BTN   (N_BTN),
        .DEB_CYC (DEB_CYC),
        .LONG_CYC(LONG_CYC),
        .REP_CYC (REP_CYC),
        .CNT_W   (8)
    ) dut (
        .clk10hz   (clk10hz),
        .rst_n     (rst_n),
        .pb        (pb),
        .repEn     (repEn),
        .pressed   (pressed),
        .shortPulse(shortPulse),
        .isKP      (isKP),
        .repPulse  (repPulse)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: a 2-sample delay, a sliding window for debounce, and press age in ticks
    logic [N_BTN-1:0]   m_d1, m_d2, m_deb, m_short, m_kp, m_rep;
    logic [DEB_CYC-1:0] m_win [N_BTN];
    int                 m_nwin [N_BTN];
    int                 m_start [N_BTN];
    int                 m_run [N_BTN];
    int                 m_t = 0;

    int               n_press [N_BTN];
    int               n_short [N_BTN];
    int               n_rep [N_BTN];
    int               n_kp [N_BTN];
    logic [N_BTN-1:0] last_pressed = '0;

    typedef struct {
        int ch;
        int hold;
        bit rep;
        int exp_press;
        int exp_short;
        int exp_kp;
        int exp_rep;
    } vec_t;
    vec_t vecs [9];

    task automatic model_reset();
        m_d1    = '1;
        m_d2    = '1;
        m_deb   = '0;
        m_short = '0;
        m_kp    = '0;
        m_rep   = '0;
        for (int c = 0; c < N_BTN; c++) begin
            m_win[c]   = '0;
            m_nwin[c]  = 0;
            m_start[c] = 0;
            m_run[c]   = 0;
        end
    endtask

    task automatic model_step();
        logic raw, newdeb;
        int   age;
        for (int c = 0; c < N_BTN; c++) begin
            raw      = ~m_d2[c];
            m_d2[c]  = m_d1[c];
            m_d1[c]  = pb[c];
            m_win[c] = (m_win[c] << 1) | DEB_CYC'(raw);
            if (m_nwin[c] < DEB_CYC) m_nwin[c]++;
            newdeb = m_deb[c];
            if (m_nwin[c] == DEB_CYC && m_win[c] == {DEB_CYC{~m_deb[c]}}) newdeb = ~m_deb[c];
            m_short[c] = 1'b0;
            m_rep[c]   = 1'b0;
            if (newdeb && !m_deb[c]) begin
                m_start[c] = m_t;
            end else if (!newdeb && m_deb[c]) begin
                m_short[c] = ((m_t - m_start[c]) <= LONG_CYC);
                m_kp[c]    = 1'b0;
            end else if (newdeb) begin
                age = m_t - m_start[c];
                if (age == LONG_CYC) begin
                    m_kp[c]  = 1'b1;
                    m_run[c] = 0;
                end else if (age > LONG_CYC) begin
                    if (repEn[c]) begin
                        m_run[c]++;
                        if (m_run[c] == REP_CYC) begin
                            m_rep[c] = 1'b1;
                            m_run[c] = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
            end
            m_deb[c] = newdeb;
        end
        m_t++;
    endtask

    task automatic check_vec(input string name, input logic [N_BTN-1:0] act,
                             input logic [N_BTN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%b required=%b", name, m_t, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%0d required=%0d", name, m_t, act, exp);
        end
    endtask

    task automatic clear_obs();
        for (int c = 0; c < N_BTN; c++) begin
            n_press[c] = 0;
            n_short[c] = 0;
            n_rep[c]   = 0;
            n_kp[c]    = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk10hz);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk10hz);
        check_vec("pressed", pressed, m_deb);
        check_vec("shortPulse", shortPulse, m_short);
        check_vec("isKP", isKP, m_kp);
        check_vec("repPulse", repPulse, m_rep);
        for (int c = 0; c < N_BTN; c++) begin
            if (pressed[c] && !last_pressed[c]) n_press[c]++;
            if (shortPulse[c]) n_short[c]++;
            if (repPulse[c]) n_rep[c]++;
            if (isKP[c] && n_kp[c] == 0) n_kp[c] = 1;
        end
        last_pressed = pressed;
    endtask

    task automatic check_counts(input string tag, input int ch, input int ep, input int es,
                                input int ek, input int er);
        check_int({tag, "_press"}, n_press[ch], ep);
        check_int({tag, "_short"}, n_short[ch], es);
        check_int({tag, "_kp"}, n_kp[ch], ek);
        check_int({tag, "_rep"}, n_rep[ch], er);
    endtask

    initial begin
        int n;
        int others;

        // {ch, pb low cycles, repEn, presses, shortPulses, isKP seen, repPulses}
        vecs[0] = '{0, 1, 1'b0, 0, 0, 0, 0};   // glitch
        vecs[1] = '{0, 6, 1'b0, 1, 1, 0, 0};   // short
        vecs[2] = '{1, 20, 1'b1, 1, 0, 1, 3};  // long with repeat
        vecs[3] = '{1, 10, 1'b1, 1, 1, 0, 0};  // release on the threshold cycle
        vecs[4] = '{1, 11, 1'b1, 1, 0, 1, 0};  // just long
        vecs[5] = '{2, 20, 1'b0, 1, 0, 1, 0};  // long, repeat disabled
        vecs[6] = '{3, 2, 1'b0, 1, 1, 0, 0};   // exactly DEB_CYC
        vecs[7] = '{0, 17, 1'b1, 1, 0, 1, 2};
        vecs[8] = '{3, 16, 1'b1, 1, 0, 1, 1};  // release on a repeat boundary

        pb    = '1;
        repEn = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        check_vec("reset_outputs", pressed | shortPulse | isKP | repPulse, '0);
        rst_n = 1'b1;
        repeat (4) tick();

        foreach (vecs[i]) begin
            clear_obs();
            pb[vecs[i].ch]    = 1'b0;
            repEn[vecs[i].ch] = vecs[i].rep;
            repeat (vecs[i].hold) tick();
            pb[vecs[i].ch] = 1'b1;
            repeat (12) tick();
            repEn[vecs[i].ch] = 1'b0;
            check_counts($sformatf("vec%0d", i), vecs[i].ch, vecs[i].exp_press,
                         vecs[i].exp_short, vecs[i].exp_kp, vecs[i].exp_rep);
            others = 0;
            for (int c = 0; c < N_BTN; c++)
                if (c != vecs[i].ch) others += n_press[c] + n_short[c] + n_rep[c] + n_kp[c];
            check_int($sformatf("vec%0d_other_quiet", i), others, 0);
        end

        // Press latency from the pb edge
        clear_obs();
        pb[0] = 1'b0;
        n = 0;
        while (!pressed[0] && n < 20) begin
            tick();
            n++;
        end
        check_int("press_latency", n, 4);
        pb[0] = 1'b1;
        repeat (10) tick();

        // Overlapping short (ch2) and long (ch3) presses
        clear_obs();
        pb[3] = 1'b0;
        repEn[3] = 1'b1;
        repeat (3) tick();
        pb[2] = 1'b0;
        repeat (6) tick();
        pb[2] = 1'b1;
        repeat (11) tick();
        pb[3] = 1'b1;
        repeat (12) tick();
        repEn[3] = 1'b0;
        check_counts("indep_ch2", 2, 1, 1, 0, 0);
        check_counts("indep_ch3", 3, 1, 0, 1, 3);

        // Reset asserted during a long hold
        pb[1] = 1'b0;
        repEn[1] = 1'b1;
        n = 0;
        while (!isKP[1] && n < 30) begin
            tick();
            n++;
        end
        check_int("kp_before_reset", n, 14);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_vec("async_reset_outputs", pressed | shortPulse | isKP | repPulse, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        while (!isKP[1] && n < 30) begin
            tick();
            n++;
        end
        check_int("kp_after_reset", n, 14);
        pb[1] = 1'b1;
        repEn[1] = 1'b0;
        repeat (10) tick();

        // Random presses, releases and repeat-enable changes against the model
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < N_BTN; c++) begin
                if (pb[c]) begin
                    if ($urandom_range(9) == 0) pb[c] = 1'b0;
                end else if ($urandom_range(23) == 0) begin
                    pb[c] = 1'b1;
                end
                if ($urandom_range(15) == 0) repEn[c] = ~repEn[c];
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
